// File: rtl/otsu_pkg.sv
// Shared definitions for the Otsu threshold engine: FSM states, gray/bin
// geometry, and width helpers derived from the frame pixel count.
package otsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_SCAN,
      ST_DONE
   } otsu_state_t;

   localparam int unsigned GRAY_W = 8;
   localparam int unsigned NBINS  = 256;

   // Histogram bin: must hold a count of every pixel in the frame.
   function automatic int unsigned bin_w(input int unsigned npix);
      return $clog2(npix + 1);
   endfunction

   // Weighted gray sum over the frame (at most 255 per pixel).
   function automatic int unsigned sum_w(input int unsigned npix);
      return $clog2((NBINS - 1) * npix + 1);
   endfunction

   // NPIX*sum0 and sumT*w0 products.
   function automatic int unsigned prd_w(input int unsigned npix);
      return sum_w(npix) + bin_w(npix);
   endfunction

endpackage

// File: rtl/rgb2gray.sv
// Combinational gray conversion: floor(sum/3) of a 10-bit R+G+B sum.
module rgb2gray
   import otsu_pkg::*;
(
   input  logic [9:0]        rgb_sum,
   output logic [GRAY_W-1:0] gray
);

   assign gray = GRAY_W'(rgb_sum / 10'd3);

endmodule

// File: rtl/otsu_threshold_engine.sv
// Streaming Otsu threshold engine: builds a gray histogram over one frame,
// then runs a 3-stage integer between-class-variance search over 256 bins.
module otsu_threshold_engine
   import otsu_pkg::*;
#(
   parameter int unsigned WIDTH  = 768,
   parameter int unsigned HEIGHT = 512
) (
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic       VSYNC,
   input  logic       HSYNC,
   input  logic [7:0] DATA_R0,
   input  logic [7:0] DATA_G0,
   input  logic [7:0] DATA_B0,
   input  logic [7:0] DATA_R1,
   input  logic [7:0] DATA_G1,
   input  logic [7:0] DATA_B1,
   output logic [7:0] thresh,
   output logic       thresh_valid,
   output logic       busy,
   output logic       frame_err
);

   localparam int unsigned NPIX      = WIDTH * HEIGHT;
   localparam int unsigned NPAIR     = NPIX / 2;
   localparam int unsigned PAIR_W    = $clog2(NPAIR + 1);
   localparam int unsigned BIN_W     = bin_w(NPIX);
   localparam int unsigned SUM_W     = sum_w(NPIX);
   localparam int unsigned PRD_W     = prd_w(NPIX);
   localparam int unsigned NUM_W     = 2 * PRD_W;
   localparam int unsigned DEN_W     = 2 * BIN_W;
   localparam int unsigned CMP_W     = NUM_W + DEN_W;
   localparam int unsigned TP_W      = GRAY_W + BIN_W;
   localparam int unsigned SCAN_LAST = NBINS + 2;

   otsu_state_t state, state_nxt;
   logic vsync_d, vs_rise;
   logic frame_start, accept, err_nxt, scan_done, scan_rd_en;

   logic [PAIR_W-1:0]  pair_cnt;
   logic [SUM_W-1:0]   sum_t;
   logic [NBINS-1:0]   bin_vld;
   logic [BIN_W-1:0]   hist [NBINS];

   logic [9:0]         pix_sum0, pix_sum1;
   logic [GRAY_W-1:0]  g0, g1;
   logic [BIN_W-1:0]   rd0, rd1, rd_scan;

   logic [8:0]         scan_cnt;
   logic [GRAY_W-1:0]  scan_t;
   logic [TP_W-1:0]    t_prod;

   logic               s1_v;
   logic [GRAY_W-1:0]  s1_t;
   logic [BIN_W-1:0]   acc_w0;
   logic [SUM_W-1:0]   acc_sum0;

   logic [PRD_W-1:0]   prd_a, prd_b, prd_mag;
   logic [NUM_W-1:0]   num_c;
   logic [DEN_W-1:0]   den_c;
   logic               vld_c;

   logic               s2_v;
   logic [GRAY_W-1:0]  s2_t;
   logic [NUM_W-1:0]   s2_num;
   logic [DEN_W-1:0]   s2_den;

   logic [CMP_W-1:0]   cmp_lhs, cmp_rhs;
   logic [NUM_W-1:0]   best_num;
   logic [DEN_W-1:0]   best_den;
   logic [GRAY_W-1:0]  best_t;

   assign pix_sum0 = {2'b00, DATA_R0} + {2'b00, DATA_G0} + {2'b00, DATA_B0};
   assign pix_sum1 = {2'b00, DATA_R1} + {2'b00, DATA_G1} + {2'b00, DATA_B1};

   rgb2gray u_gray0 (.rgb_sum(pix_sum0), .gray(g0));
   rgb2gray u_gray1 (.rgb_sum(pix_sum1), .gray(g1));

   assign vs_rise = VSYNC & ~vsync_d;
   assign busy    = (state == ST_SCAN);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state   <= ST_IDLE;
         vsync_d <= 1'b0;
      end else begin
         state   <= state_nxt;
         vsync_d <= VSYNC;
      end
   end

   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      accept      = 1'b0;
      scan_done   = 1'b0;
      err_nxt     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (vs_rise) begin
               state_nxt   = ST_ACCUM;
               frame_start = 1'b1;
            end
         end
         ST_ACCUM: begin
            if (vs_rise) begin
               frame_start = 1'b1;
               err_nxt     = 1'b1;
            end else if (HSYNC) begin
               accept = 1'b1;
               if (pair_cnt == PAIR_W'(NPAIR - 1))
                  state_nxt = ST_SCAN;
            end
         end
         ST_SCAN: begin
            err_nxt = HSYNC;
            if (scan_cnt == 9'(SCAN_LAST)) begin
               state_nxt = ST_DONE;
               scan_done = 1'b1;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Bins whose valid bit is low read as zero, so a frame start clears the
   // whole histogram in one cycle without touching the count registers.
   assign rd0     = bin_vld[g0]     ? hist[g0]     : '0;
   assign rd1     = bin_vld[g1]     ? hist[g1]     : '0;
   assign rd_scan = bin_vld[scan_t] ? hist[scan_t] : '0;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pair_cnt <= '0;
         sum_t    <= '0;
         bin_vld  <= '0;
      end else if (frame_start) begin
         pair_cnt <= '0;
         sum_t    <= '0;
         bin_vld  <= '0;
      end else if (accept) begin
         pair_cnt    <= pair_cnt + PAIR_W'(1);
         sum_t       <= sum_t + SUM_W'(g0) + SUM_W'(g1);
         bin_vld[g0] <= 1'b1;
         bin_vld[g1] <= 1'b1;
      end
   end

   // Read-modify-write completes within the accepting cycle, so a following
   // pair to the same bin already reads the updated count.
   always_ff @(posedge HCLK) begin
      if (accept) begin
         if (g0 == g1) begin
            hist[g0] <= rd0 + BIN_W'(2);
         end else begin
            hist[g0] <= rd0 + BIN_W'(1);
            hist[g1] <= rd1 + BIN_W'(1);
         end
      end
   end

   assign scan_t     = scan_cnt[GRAY_W-1:0];
   assign scan_rd_en = (state == ST_SCAN) && (scan_cnt < 9'(NBINS));
   assign t_prod     = {{BIN_W{1'b0}}, scan_t} * {{GRAY_W{1'b0}}, rd_scan};

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         scan_cnt <= '0;
      else if (state == ST_SCAN)
         scan_cnt <= scan_cnt + 9'd1;
      else
         scan_cnt <= '0;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         s1_v     <= 1'b0;
         s1_t     <= '0;
         acc_w0   <= '0;
         acc_sum0 <= '0;
      end else begin
         s1_v <= scan_rd_en;
         s1_t <= scan_t;
         if (frame_start) begin
            acc_w0   <= '0;
            acc_sum0 <= '0;
         end else if (scan_rd_en) begin
            acc_w0   <= acc_w0 + rd_scan;
            acc_sum0 <= acc_sum0 + SUM_W'(t_prod);
         end
      end
   end

   // Signed difference handled as a magnitude; its square is all that matters.
   assign prd_a   = PRD_W'(NPIX) * PRD_W'(acc_sum0);
   assign prd_b   = PRD_W'(sum_t) * PRD_W'(acc_w0);
   assign prd_mag = (prd_a >= prd_b) ? (prd_a - prd_b) : (prd_b - prd_a);
   assign num_c   = NUM_W'(prd_mag) * NUM_W'(prd_mag);
   assign den_c   = DEN_W'(acc_w0) * DEN_W'(BIN_W'(NPIX) - acc_w0);
   assign vld_c   = s1_v && (acc_w0 != '0) && (acc_w0 != BIN_W'(NPIX));

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         s2_v   <= 1'b0;
         s2_t   <= '0;
         s2_num <= '0;
         s2_den <= '0;
      end else begin
         s2_v   <= vld_c;
         s2_t   <= s1_t;
         s2_num <= num_c;
         s2_den <= den_c;
      end
   end

   assign cmp_lhs = CMP_W'(s2_num) * CMP_W'(best_den);
   assign cmp_rhs = CMP_W'(best_num) * CMP_W'(s2_den);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         best_num <= '0;
         best_den <= DEN_W'(1);
         best_t   <= '0;
      end else if (frame_start) begin
         best_num <= '0;
         best_den <= DEN_W'(1);
         best_t   <= '0;
      end else if (s2_v && (cmp_lhs > cmp_rhs)) begin
         best_num <= s2_num;
         best_den <= s2_den;
         best_t   <= s2_t;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         thresh       <= '0;
         thresh_valid <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         thresh_valid <= scan_done;
         frame_err    <= err_nxt;
         if (scan_done)
            thresh <= best_t;
      end
   end

endmodule

// File: doc/otsu_threshold_engine.md
# otsu_threshold_engine

Streaming Otsu threshold engine. Sits directly downstream of the image reader and consumes its HSYNC-qualified two-pixels-per-cycle RGB888 stream. It converts each pixel to gray, builds a 256-bin histogram over one frame, then runs a sequential integer Otsu search. It outputs the 8-bit optimal threshold with a one-cycle valid pulse. This replaces the behavioural floating-point threshold search with synthesizable hardware.

## Interface
- WIDTH, 768, image width in pixels (even)
- HEIGHT, 512, image height in lines
- NPIX, WIDTH*HEIGHT, pixels per frame (derived; not overridable)

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous, active-low reset
- VSYNC  in  1  frame-start window; a rising edge starts a new frame
- HSYNC  in  1  pixel-pair valid
- DATA_R0/G0/B0  in  8 each  even pixel
- DATA_R1/G1/B1  in  8 each  odd pixel
- thresh  out  8  last computed threshold; pixels with gray > thresh are foreground
- thresh_valid  out  1  one-cycle pulse when thresh updates
- busy  out  1  high in SCAN
- frame_err  out  1  one-cycle pulse on a short frame or on input during SCAN

## Operation
- Reset values: thresh=0, thresh_valid=0, busy=0, frame_err=0. The FSM enters IDLE and all counters and accumulators clear.
- Gray conversion: gray = floor((R+G+B)/3). Sum is 10-bit, result 0..255. Example: (255,0,1) gives 85.
- States and transitions:
  - IDLE: waits for a VSYNC rising edge, then goes to ACCUM.
  - ACCUM: accumulates pixel pairs; goes to SCAN after the last pair.
  - SCAN: runs the threshold search; goes to DONE when the search completes.
  - DONE: lasts one cycle, then returns to IDLE.
- Frame start (VSYNC rising edge):
  - clears the 256-bit bin-valid vector in one cycle, so a bin with its valid bit low reads as 0;
  - clears pair_cnt, sumT and the error state.
- ACCUM, on each HSYNC cycle:
  - hist[g0]+=1 and hist[g1]+=1; if g0==g1 the bin gets +2;
  - sumT += g0+g1;
  - pair_cnt += 1.
  - When pair_cnt reaches NPIX/2, the FSM goes to SCAN.
- Bin width: ceil(log2(NPIX+1)), 19 bits at the defaults. No saturation is needed.
- SCAN, for t = 0..255, one bin per cycle:
  - w0 += hist[t]; sum0 += t*hist[t];
  - t is valid only when 0 < w0 < NPIX;
  - num = (NPIX*sum0 − sumT*w0)², signed difference, unsigned square;
  - den = w0*(NPIX−w0);
  - the candidate wins if num*best_den > best_num*den (strict greater-than). Ties therefore keep the lowest t.
  - Initial best_num=0 and best_den=1, so the first valid t with num>0 wins.
- Result: if no t wins (uniform image), thresh=0.
- Input rules:
  - HSYNC outside ACCUM is ignored; if it arrives during SCAN, frame_err pulses.
  - A VSYNC rising edge during ACCUM (short frame) pulses frame_err and restarts ACCUM.
  - A VSYNC rising edge during SCAN is ignored; the next frame is missed.
- thresh holds its value until the next DONE.

## Timing
- Histogram update is one read-modify-write per cycle. A back-to-back HSYNC to the same bin must see the updated count, via a bypass/forward register.
- SCAN starts the cycle after the last pair is accepted.
- SCAN pipeline has 3 stages: accumulate → num/den products → cross-multiply compare.
- thresh and thresh_valid update exactly 260 cycles after the cycle that accepts the last pair. busy is high for cycles 1..259 of that interval.
- Asynchronous reset at any time, including mid-SCAN, forces the reset values immediately. No thresh_valid is produced for the aborted frame.

## Structure
- Shared package otsu_pkg: state encoding (ST_IDLE, ST_ACCUM, ST_SCAN, ST_DONE), GRAY_W=8, NBINS=256, and width functions for bins, sums and products.
- Sub-module rgb2gray: combinational divide-by-3 of a 10-bit sum. It is instantiated twice, once per pixel.
- The histogram is a register array plus valid-bit vector inside the engine.

## Test plan
Bench uses WIDTH=8, HEIGHT=4 (16 pairs).

1. Every pixel RGB=(128,128,128) → no valid t; after 260 cycles thresh=0 with one thresh_valid pulse.
2. Half the pixels gray 50, half gray 200 → all t in 50..199 tie; thresh=50.
3. Each pair has an even pixel of gray 10 and an odd pixel of gray 240 (same-cycle different bins) → thresh=10. Repeat with both pixels of every pair at gray 10 for half the frame (same-bin +2 and back-to-back forwarding) → hist[10]=16 and thresh=10.
4. RGB=(255,0,1) in one pixel, all others (0,0,0) → gray 85 binned; thresh=0.
5. VSYNC re-rises after 9 pairs → frame_err pulse; the new frame completes normally. HSYNC during SCAN → frame_err pulse; the result is unaffected.
6. HRESETn low at SCAN cycle 100 → all outputs return to reset values; no thresh_valid; the next frame produces the correct result.
